// File: rtl/exception_arbiter.sv
//------------------------------------------------------------------------------
// exception_arbiter
// Latches the four exception/interrupt sources of the multicycle CPU,
// applies the per-type enable mask and picks one by fixed priority
// (access-invalid > misalign > overflow > input). It then runs the
// request/acknowledge handshake with the control FSM.
// Optional feature macro: EXC_DROP_COUNT_EN (saturating dropped-event counter).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exception_arbiter #(
  parameter int DROP_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ovfl,
  input  logic              AccInv,
  input  logic              Misalign,
  input  logic              InputRecv,
  input  logic [3:0]        mask,
  input  logic              exc_ack,
  input  logic              eret,
  output logic              exc_req,
  output logic [1:0]        ExType,
  output logic              KernelMode,
  output logic              InputRst,
  output logic [3:0]        pending,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_RETIRE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] extype_q, extype_d;
  logic [3:0] pend_q, pend_d;

  logic [3:0] w_ev;       // raw events, bit n = ExType n
  logic [3:0] w_ev_keep;  // events that are allowed to latch
  logic [3:0] w_elig;     // eligible set
  logic [3:0] w_clr;      // pending bit retired by the acknowledge
  logic [1:0] w_prio;     // highest-priority eligible type

  assign w_ev      = {Misalign, AccInv, ovfl, InputRecv};
  // Masked synchronous events are thrown away; input interrupts always wait.
  assign w_ev_keep = {w_ev[3:1] & mask[3:1], w_ev[0]};
  assign w_elig    = (pend_q | w_ev_keep) & mask;

  // Fixed priority select: 2 > 3 > 1 > 0.
  always_comb begin
    w_prio = 2'd0;
    if (w_elig[2])      w_prio = 2'd2;
    else if (w_elig[3]) w_prio = 2'd3;
    else if (w_elig[1]) w_prio = 2'd1;
  end

  // Pending update: a new event on the acknowledge edge beats the clear.
  always_comb begin
    w_clr = 4'b0000;
    if (state_q == S_REQ && exc_ack) w_clr = 4'b0001 << extype_q;
    pend_d = (pend_q & ~w_clr) | w_ev_keep;
  end

  // State, committed type and pending register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      extype_q <= 2'd0;
      pend_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      extype_q <= extype_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state logic; the type is only committed on IDLE->REQ.
  always_comb begin
    state_d  = state_q;
    extype_d = extype_q;
    case (state_q)
      S_IDLE: begin
        if (w_elig != 4'b0000) begin
          state_d  = S_REQ;
          extype_d = w_prio;
        end
      end
      S_REQ:     if (exc_ack) state_d = S_SERVICE;
      S_SERVICE: if (eret)    state_d = S_RETIRE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registers.
  always_comb begin
    exc_req    = (state_q == S_REQ);
    KernelMode = (state_q != S_IDLE);
    InputRst   = (state_q == S_RETIRE) && (extype_q == 2'd0);
    ExType     = extype_q;
    pending    = pend_q;
  end

`ifdef EXC_DROP_COUNT_EN
  logic              w_dropped;
  logic [DROP_W-1:0] drop_q;

  assign w_dropped = |(w_ev[3:1] & ~mask[3:1]);

  // Saturating count of edges on which a synchronous event was discarded.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      drop_q <= '0;
    end else if (w_dropped && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exception_arbiter.sv
//------------------------------------------------------------------------------
// tb_exception_arbiter
// Scoreboard bench: expected ExType values are queued as events are driven
// and popped when the arbiter raises exc_req.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_exception_arbiter;

  localparam int DW = 8;
`ifdef EXC_DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Reset;
  logic          ovfl, AccInv, Misalign, InputRecv;
  logic [3:0]    mask;
  logic          exc_ack, eret;
  logic          exc_req;
  logic [1:0]    ExType;
  logic          KernelMode, InputRst;
  logic [3:0]    pending;
  logic [DW-1:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;
  logic [1:0] exp_q[$];

  exception_arbiter #(.DROP_W(DW)) dut (
    .CLK(CLK), .Reset(Reset),
    .ovfl(ovfl), .AccInv(AccInv), .Misalign(Misalign), .InputRecv(InputRecv),
    .mask(mask), .exc_ack(exc_ack), .eret(eret),
    .exc_req(exc_req), .ExType(ExType), .KernelMode(KernelMode),
    .InputRst(InputRst), .pending(pending), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive an event vector (bit n = ExType n) for one edge.
  task automatic drive_ev(input logic [3:0] ev);
    {Misalign, AccInv, ovfl, InputRecv} = ev;
  endtask

  task automatic pulse(input logic [3:0] ev);
    drive_ev(ev);
    @(negedge CLK);
    drive_ev(4'b0000);
  endtask

  task automatic bump_drop();
    if (CNT_EN) exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !exc_req; i++) @(negedge CLK);
    check({tag, "_req_seen"}, {31'd0, exc_req}, 32'd1);
  endtask

  // One full handshake, with optional events on the ack edge and in SERVICE.
  task automatic serve(input string tag, input logic [3:0] ev_ack, input logic [3:0] ev_srv,
                       input logic [3:0] pend_ack, input logic [3:0] pend_srv,
                       input logic exp_inrst);
    logic [1:0] e;
    wait_req(tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      e = 2'd0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_extype"}, {30'd0, ExType}, {30'd0, e});
    check({tag, "_kernel_req"}, {31'd0, KernelMode}, 32'd1);
    exc_ack = 1'b1;
    drive_ev(ev_ack);
    @(negedge CLK);
    exc_ack = 1'b0;
    drive_ev(4'b0000);
    check({tag, "_req_low"}, {31'd0, exc_req}, 32'd0);
    check({tag, "_pend_ack"}, {28'd0, pending}, {28'd0, pend_ack});
    drive_ev(ev_srv);
    @(negedge CLK);
    drive_ev(4'b0000);
    check({tag, "_srv_req"}, {31'd0, exc_req}, 32'd0);
    check({tag, "_pend_srv"}, {28'd0, pending}, {28'd0, pend_srv});
    eret = 1'b1;
    @(negedge CLK);
    eret = 1'b0;
    check({tag, "_inrst"}, {31'd0, InputRst}, {31'd0, exp_inrst});
    check({tag, "_kernel_ret"}, {31'd0, KernelMode}, 32'd1);
    @(negedge CLK);
    check({tag, "_inrst_off"}, {31'd0, InputRst}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, exc_req}, 32'd0);
    check({tag, "_extype"}, {30'd0, ExType}, 32'd0);
    check({tag, "_kernel"}, {31'd0, KernelMode}, 32'd0);
    check({tag, "_inrst"}, {31'd0, InputRst}, 32'd0);
    check({tag, "_pend"}, {28'd0, pending}, 32'd0);
    check({tag, "_drop"}, {24'd0, drop_count}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; mask = 4'hF; exc_ack = 1'b0; eret = 1'b0;
    drive_ev(4'b0000);
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    Reset = 1'b0;
    @(negedge CLK);

    // Single overflow.
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    check("ovfl_req_latency", {31'd0, exc_req}, 32'd1);
    serve("ovfl", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    check("ovfl_kernel_idle", {31'd0, KernelMode}, 32'd0);

    // Three synchronous events together: priority 2, 3, 1.
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    pulse(4'b1110);
    serve("prio_a", 4'h0, 4'h0, 4'b1010, 4'b1010, 1'b0);
    serve("prio_b", 4'h0, 4'h0, 4'b0010, 4'b0010, 1'b0);
    serve("prio_c", 4'h0, 4'h0, 4'b0000, 4'b0000, 1'b0);

    // Masked misalign is dropped and counted, saturating.
    mask = 4'b0111;
    pulse(4'b1000);
    bump_drop();
    check("drop_req", {31'd0, exc_req}, 32'd0);
    check("drop_pend", {28'd0, pending}, 32'd0);
    check("drop_one", {24'd0, drop_count}, exp_drop);
    drive_ev(4'b1000);
    for (int i = 0; i < 299; i++) begin
      @(negedge CLK);
      bump_drop();
    end
    drive_ev(4'b0000);
    @(negedge CLK);
    check("drop_sat", {24'd0, drop_count}, exp_drop);
    check("drop_sat_pend", {28'd0, pending}, 32'd0);

    // Input interrupt held while masked, serviced once enabled.
    mask = 4'b1110;
    pulse(4'b0001);
    repeat (2) @(negedge CLK);
    check("in_masked_pend", {28'd0, pending}, 32'd1);
    check("in_masked_req", {31'd0, exc_req}, 32'd0);
    mask = 4'hF;
    exp_q.push_back(2'd0);
    @(negedge CLK);
    check("in_unmask_req", {31'd0, exc_req}, 32'd1);
    serve("input", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Overflow during SERVICE, then overflow on the acknowledge edge.
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    serve("nest_a", 4'h0, 4'b0010, 4'h0, 4'b0010, 1'b0);
    exp_q.push_back(2'd1);
    serve("nest_b", 4'b0010, 4'h0, 4'b0010, 4'b0010, 1'b0);
    exp_q.push_back(2'd1);
    serve("nest_c", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    check("nest_kernel_idle", {31'd0, KernelMode}, 32'd0);

    // Asynchronous reset in SERVICE with pending = 1010.
    pulse(4'b0010);
    wait_req("arst");
    exc_ack = 1'b1;
    @(negedge CLK);
    exc_ack = 1'b0;
    pulse(4'b1010);
    check("arst_pre_pend", {28'd0, pending}, 32'hA);
    check("arst_pre_kernel", {31'd0, KernelMode}, 32'd1);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("arst");
    @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    check("arst_after_req", {31'd0, exc_req}, 32'd0);
    check("arst_after_pend", {28'd0, pending}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
